// File: rtl/mrna_iso_pkg.sv
// mrna_iso_pkg: state codes, ctrl bit map, per-state valve
// masks and the peristaltic pump phase table.
package mrna_iso_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_CELLS = 4'd1,
    S_LOAD_BEADS = 4'd2,
    S_LYSIS      = 4'd3,
    S_MIX        = 4'd4,
    S_WASH       = 4'd5,
    S_COLLECT    = 4'd6,
    S_FLUSH      = 4'd7
  } state_t;

  localparam int B_COLLECT   = 0;
  localparam int B_LYSIS_IN  = 1;
  localparam int B_LYSIS_OUT = 2;
  localparam int B_PUSH      = 3;
  localparam int B_PUMP1     = 4;
  localparam int B_PUMP2     = 5;
  localparam int B_PUMP3     = 6;
  localparam int B_SEP       = 7;
  localparam int B_SIEVE     = 8;
  localparam int B_WASTE     = 9;
  localparam int B_BEADS     = 10;
  localparam int B_CELLS_IN  = 11;
  localparam int B_CELLS_OUT = 12;
  localparam int CTRL_W      = B_CELLS_OUT + 1;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t M_LOAD_CELLS = ctrl_t'(
    (1 << B_CELLS_IN) | (1 << B_SIEVE) | (1 << B_WASTE));
  localparam ctrl_t M_LOAD_BEADS = ctrl_t'(
    (1 << B_BEADS) | (1 << B_SIEVE) | (1 << B_WASTE));
  localparam ctrl_t M_LYSIS = ctrl_t'(
    (1 << B_LYSIS_IN) | (1 << B_LYSIS_OUT));
  localparam ctrl_t M_MIX = ctrl_t'(1 << B_SEP);
  localparam ctrl_t M_WASH = ctrl_t'(
    (1 << B_LYSIS_IN) | (1 << B_SEP) |
    (1 << B_SIEVE) | (1 << B_WASTE));
  localparam ctrl_t M_COLLECT = ctrl_t'(
    (1 << B_PUSH) | (1 << B_COLLECT) | (1 << B_SIEVE));

  localparam int N_PHASE = 6;

  localparam ctrl_t PUMP_TAB [N_PHASE] = '{
    ctrl_t'(1 << B_PUMP1),
    ctrl_t'((1 << B_PUMP2) | (1 << B_PUMP1)),
    ctrl_t'(1 << B_PUMP2),
    ctrl_t'((1 << B_PUMP3) | (1 << B_PUMP2)),
    ctrl_t'(1 << B_PUMP3),
    ctrl_t'((1 << B_PUMP3) | (1 << B_PUMP1))
  };

  function automatic ctrl_t state_mask(state_t s);
    case (s)
      S_LOAD_CELLS: return M_LOAD_CELLS;
      S_LOAD_BEADS: return M_LOAD_BEADS;
      S_LYSIS:      return M_LYSIS;
      S_MIX:        return M_MIX;
      S_WASH:       return M_WASH;
      S_COLLECT:    return M_COLLECT;
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/mrna_iso_tick_gen.sv
// mrna_iso_tick_gen: dwell prescaler, one tick per TICK_DIV
// running cycles; restarts on clear, freezes on pause.
module mrna_iso_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic pause,
  output logic tick
);

  localparam int DIV = (TICK_DIV < 1) ? 1 : TICK_DIV;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = !pause && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mrna_iso_sequencer.sv
// mrna_iso_sequencer: isolation recipe sequencer for one bank.
// Define MRNAISO_FLUSH_EN to add a FLUSH step after COLLECT.
module mrna_iso_sequencer
  import mrna_iso_pkg::*;
#(
  parameter int TICK_DIV     = 1000,
  parameter int T_LOAD_CELLS = 8,
  parameter int T_LOAD_BEADS = 8,
  parameter int T_LYSIS      = 16,
  parameter int T_MIX        = 64,
  parameter int T_WASH       = 16,
  parameter int T_COLLECT    = 16,
  parameter int PUMP_TICKS   = 2,
  parameter int T_FLUSH      = 8,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [3:0]        step,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CTRL_W-1:0] flush
);

  localparam int PT = (PUMP_TICKS < 1) ? 1 : PUMP_TICKS;

  state_t           state, state_n;
  logic [CNT_W-1:0] dwell, dwell_n;
  logic [CNT_W-1:0] ptick, ptick_n;
  logic [2:0]       phase, phase_n;
  logic             tick, clear, expire;
  logic             done_n, aborted_n;
  ctrl_t            ctrl_n;

  function automatic logic [CNT_W-1:0] last_tick(state_t s);
    int t;
    case (s)
      S_LOAD_CELLS: t = T_LOAD_CELLS;
      S_LOAD_BEADS: t = T_LOAD_BEADS;
      S_LYSIS:      t = T_LYSIS;
      S_MIX:        t = T_MIX;
      S_WASH:       t = T_WASH;
      S_COLLECT:    t = T_COLLECT;
      S_FLUSH:      t = T_FLUSH;
      default:      t = 1;
    endcase
    if (t < 1) t = 1;
    return CNT_W'(t - 1);
  endfunction

  // Prescaler restarts whenever the state changes or we sit idle
  assign clear = (state_n != state) || (state == S_IDLE);

  mrna_iso_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .pause (pause),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    expire    = tick && (dwell == last_tick(state));
    if (state == S_IDLE) begin
      if (start) state_n = S_LOAD_CELLS;
    end else if (abort) begin
      state_n   = S_IDLE;
      aborted_n = 1'b1;
    end else if (expire) begin
      unique case (state)
        S_LOAD_CELLS: state_n = S_LOAD_BEADS;
        S_LOAD_BEADS: state_n = S_LYSIS;
        S_LYSIS:      state_n = S_MIX;
        S_MIX:        state_n = S_WASH;
        S_WASH:       state_n = S_COLLECT;
`ifdef MRNAISO_FLUSH_EN
        S_COLLECT:    state_n = S_FLUSH;
`endif
        default: begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    dwell_n = dwell;
    ptick_n = ptick;
    phase_n = phase;
    if (clear) begin
      dwell_n = '0;
      ptick_n = '0;
      phase_n = '0;
    end else if (tick) begin
      dwell_n = dwell + 1'b1;
      if (state == S_MIX) begin
        if (ptick == CNT_W'(PT - 1)) begin
          ptick_n = '0;
          phase_n = (phase == 3'(N_PHASE - 1)) ?
                    3'd0 : phase + 1'b1;
        end else begin
          ptick_n = ptick + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_n = state_mask(state_n);
    if (state_n == S_MIX) ctrl_n = ctrl_n | PUMP_TAB[phase_n];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell   <= '0;
      ptick   <= '0;
      phase   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      step    <= '0;
      ctrl    <= '0;
    end else begin
      dwell   <= dwell_n;
      ptick   <= ptick_n;
      phase   <= phase_n;
      busy    <= (state_n != S_IDLE);
      done    <= done_n;
      aborted <= aborted_n;
      step    <= state_n;
      ctrl    <= ctrl_n;
    end
  end

`ifdef MRNAISO_FLUSH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush <= '0;
    end else begin
      flush <= (state_n == S_FLUSH) ? '1 : '0;
    end
  end
`else
  assign flush = '0;
`endif

endmodule
